// File: rtl/lsb_mem_port.sv
// lsb_mem_port: byte-serial RAM-bus responder serving one LSB load or store at a time
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rdy                 global enable; low freezes every register and suppresses mem_wr
//   rob_clear           pipeline flush; aborts a load, never a store
//   in_lsb_ready        request valid (op_in, instr_type_in, data_addr_in, data_in)
//   welcome_lsb         idle, a request may be issued
//   cache_ready         one-cycle completion pulse with cache_instr_type / cache_data_out
//   mem_din/mem_dout    RAM read byte (1-cycle latency) / RAM write byte
//   mem_a, mem_wr       RAM byte address, write strobe
//   io_buffer_full      holds store bytes aimed at the IO window
module lsb_mem_port #(
    parameter logic [31:0] IO_BASE = 32'h00030000,
    parameter logic [6:0]  LD_TYPE = 7'b0000011,
    parameter logic [6:0]  S_TYPE  = 7'b0100011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rob_clear,
    input  logic        in_lsb_ready,
    input  logic [2:0]  op_in,
    input  logic [6:0]  instr_type_in,
    input  logic [31:0] data_addr_in,
    input  logic [31:0] data_in,
    output logic        welcome_lsb,
    output logic        cache_ready,
    output logic [6:0]  cache_instr_type,
    output logic [31:0] cache_data_out,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);
    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;
    state_t      state_q;
    logic [2:0]  op_q, cnt_q, n_q;
    logic [31:0] data_q, buf_q, a_q, out_q;
    logic [7:0]  dout_q;
    logic [6:0]  type_q;
    logic        welcome_q, ready_q, wr_q;
    logic [31:0] word_d, ext_d;
    logic [7:0]  byte_d;
    logic        io_stall;
    // In LOAD, cnt_q counts edges since acceptance; the byte on mem_din belongs to index cnt_q-1.
    always_comb begin
        word_d   = buf_q | ({24'd0, mem_din} << {cnt_q[1:0] - 2'd1, 3'b000});
        ext_d    = op_q[1] ? word_d
                 : op_q[2] ? (op_q[0] ? {16'd0, word_d[15:0]} : {24'd0, word_d[7:0]})
                 : op_q[0] ? {{16{word_d[15]}}, word_d[15:0]} : {{24{word_d[7]}}, word_d[7:0]};
        byte_d   = data_q[{cnt_q[1:0] + 2'd1, 3'b000} +: 8];
        io_stall = (state_q == STORE) && io_buffer_full && ((a_q - IO_BASE) < 32'd8);
    end
    assign welcome_lsb      = welcome_q;
    assign cache_ready      = ready_q;
    assign cache_instr_type = type_q;
    assign cache_data_out   = out_q;
    assign mem_dout         = dout_q;
    assign mem_a            = a_q;
    // A stalled IO byte and a frozen pipeline must never reach the bus as a write.
    assign mem_wr           = wr_q & rdy & ~io_stall;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            n_q       <= '0;
            data_q    <= '0;
            buf_q     <= '0;
            a_q       <= '0;
            out_q     <= '0;
            dout_q    <= '0;
            type_q    <= '0;
            welcome_q <= 1'b1;
            ready_q   <= 1'b0;
            wr_q      <= 1'b0;
        end else if (rdy) begin
            case (state_q)
                IDLE: if (in_lsb_ready && !rob_clear) begin
                    op_q      <= op_in;
                    n_q       <= op_in[1] ? 3'd4 : op_in[0] ? 3'd2 : 3'd1;
                    cnt_q     <= '0;
                    data_q    <= data_in;
                    buf_q     <= '0;
                    a_q       <= data_addr_in;
                    dout_q    <= data_in[7:0];
                    welcome_q <= 1'b0;
                    wr_q      <= instr_type_in == S_TYPE;
                    state_q   <= (instr_type_in == S_TYPE) ? STORE : LOAD;
                end
                LOAD: if (rob_clear) begin
                    state_q   <= IDLE;
                    welcome_q <= 1'b1;
                end else if (cnt_q == n_q) begin
                    state_q <= DONE;
                    ready_q <= 1'b1;
                    type_q  <= LD_TYPE;
                    out_q   <= ext_d;
                end else begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q != 3'd0) buf_q <= word_d;
                    if (cnt_q + 3'd1 < n_q) a_q <= a_q + 32'd1;
                end
                STORE: if (!io_stall) begin
                    if (cnt_q == n_q - 3'd1) begin
                        state_q <= DONE;
                        wr_q    <= 1'b0;
                        ready_q <= 1'b1;
                        type_q  <= S_TYPE;
                        out_q   <= '0;
                    end else begin
                        cnt_q  <= cnt_q + 3'd1;
                        a_q    <= a_q + 32'd1;
                        dout_q <= byte_d;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    ready_q   <= 1'b0;
                    welcome_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsb_mem_port.sv
// tb_lsb_mem_port: directed bench for lsb_mem_port with a transaction-level reference model
module tb_lsb_mem_port;
    localparam logic [6:0]  LD = 7'b0000011;
    localparam logic [6:0]  ST = 7'b0100011;
    localparam logic [31:0] IO = 32'h00030000;
    logic        clk = 1'b0;
    logic        rst, rdy, rob_clear, in_lsb_ready, io_buffer_full;
    logic [2:0]  op_in;
    logic [6:0]  instr_type_in;
    logic [31:0] data_addr_in, data_in;
    logic        welcome_lsb, cache_ready, mem_wr;
    logic [6:0]  cache_instr_type;
    logic [31:0] cache_data_out, mem_a;
    logic [7:0]  mem_din, mem_dout;
    int checks = 0, fails = 0, cyc = 0, acc = 0;
    logic [7:0]  ram [1024];
    logic [39:0] wlog [$];
    always #5 clk = ~clk;
    lsb_mem_port dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear), .in_lsb_ready(in_lsb_ready),
        .op_in(op_in), .instr_type_in(instr_type_in), .data_addr_in(data_addr_in), .data_in(data_in),
        .welcome_lsb(welcome_lsb), .cache_ready(cache_ready), .cache_instr_type(cache_instr_type),
        .cache_data_out(cache_data_out), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
        .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
    );
    function automatic logic [9:0] idx(input logic [31:0] a);
        return {a[17:12], a[3:0]};
    endfunction
    function automatic bit in_io(input logic [31:0] a);
        return (a >= IO) && (a <= IO + 32'd7);
    endfunction
    // Little-endian gather of the access width, then the extension rule of the opcode.
    function automatic logic [31:0] ld_val(input logic [2:0] op, input logic [31:0] a);
        logic [31:0] w = '0;
        int n = op[1] ? 4 : op[0] ? 2 : 1;
        for (int i = 0; i < n; i++) w = w | (32'(ram[idx(a + 32'(i))]) << (8 * i));
        if (op == 3'b000) return {{24{w[7]}}, w[7:0]};
        if (op == 3'b001) return {{16{w[15]}}, w[15:0]};
        return w;
    endfunction
    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    // RAM bus: one-cycle read latency, writes logged as {addr, byte}
    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_din <= ram[idx(mem_a)];
        if (mem_wr) wlog.push_back({mem_a, mem_dout});
    end
    // Reference model: m_k counts enabled edges since acceptance (loads) or bytes written (stores)
    bit          m_busy = 1'b0, m_ld = 1'b0;
    int          m_n = 1, m_k = 0;
    logic [31:0] m_addr, m_data;
    logic [2:0]  m_op;
    logic        x_welcome, x_ready, x_wr;
    logic [6:0]  x_type;
    logic [31:0] x_data, x_a;
    logic [7:0]  x_dout;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_k <= 0; x_welcome <= 1'b1; x_ready <= 1'b0; x_wr <= 1'b0;
            x_type <= '0; x_data <= '0; x_a <= '0; x_dout <= '0;
        end else if (rdy) begin
            if (x_ready) begin
                x_ready <= 1'b0; x_welcome <= 1'b1; m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (in_lsb_ready && !rob_clear) begin
                    m_busy <= 1'b1; m_ld <= instr_type_in != ST; m_k <= 0;
                    m_n <= op_in[1] ? 4 : op_in[0] ? 2 : 1;
                    m_addr <= data_addr_in; m_data <= data_in; m_op <= op_in;
                    x_welcome <= 1'b0; x_a <= data_addr_in;
                    if (instr_type_in == ST) begin x_wr <= 1'b1; x_dout <= data_in[7:0]; end
                end
            end else if (m_ld) begin
                if (rob_clear) begin
                    m_busy <= 1'b0; x_welcome <= 1'b1;
                end else if (m_k == m_n) begin
                    x_ready <= 1'b1; x_type <= LD; x_data <= ld_val(m_op, m_addr);
                end else begin
                    m_k <= m_k + 1;
                    x_a <= m_addr + 32'((m_k + 1 < m_n) ? m_k + 1 : m_n - 1);
                end
            end else if (!(in_io(x_a) && io_buffer_full)) begin
                if (m_k + 1 == m_n) begin
                    x_ready <= 1'b1; x_wr <= 1'b0; x_type <= ST; x_data <= '0;
                end else begin
                    m_k <= m_k + 1;
                    x_a <= m_addr + 32'(m_k + 1);
                    x_dout <= 8'(m_data >> (8 * (m_k + 1)));
                end
            end
        end
    end
    always @(negedge clk) begin
        chk("welcome_lsb", 40'(welcome_lsb), 40'(x_welcome));
        chk("cache_ready", 40'(cache_ready), 40'(x_ready));
        chk("mem_wr", 40'(mem_wr), 40'(x_wr && rdy && !(in_io(x_a) && io_buffer_full)));
        if (m_busy && !x_ready) chk("mem_a", 40'(mem_a), 40'(x_a));
        if (x_wr) chk("mem_dout", 40'(mem_dout), 40'(x_dout));
        if (x_ready) begin
            chk("cache_instr_type", 40'(cache_instr_type), 40'(x_type));
            chk("cache_data_out", 40'(cache_data_out), 40'(x_data));
        end
    end
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [2:0] op, input logic [6:0] ty, input logic [31:0] a, input logic [31:0] d);
        op_in = op; instr_type_in = ty; data_addr_in = a; data_in = d; in_lsb_ready = 1'b1;
        step;
        acc = cyc;
        in_lsb_ready = 1'b0;
    endtask
    task automatic wait_ready(output int edges);
        edges = -1;
        for (int i = 0; i < 40; i++) begin
            if (cache_ready) begin
                edges = cyc - acc;
                break;
            end
            step;
        end
        if (edges < 0) begin
            checks++; fails++;
            $display("FAIL ready_timeout: cache_ready absent after 40 cycles, required within budget");
        end
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1);
    end
    logic [2:0]  t_op [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] t_a  [4] = '{32'h4000, 32'h4000, 32'h2001, 32'h2001};
    logic [31:0] t_v  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF234, 32'h0000F234};
    int          t_e  [4] = '{2, 2, 3, 3};
    logic [7:0]  sw_b [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    initial begin
        int e, seen;
        rst = 1'b0; rdy = 1'b1; rob_clear = 1'b0; in_lsb_ready = 1'b0; io_buffer_full = 1'b0;
        op_in = '0; instr_type_in = '0; data_addr_in = '0; data_in = '0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[idx(32'h1000)] = 8'h11; ram[idx(32'h1001)] = 8'h22;
        ram[idx(32'h1002)] = 8'h33; ram[idx(32'h1003)] = 8'h44;
        ram[idx(32'h4000)] = 8'h80;
        ram[idx(32'h2001)] = 8'h34; ram[idx(32'h2002)] = 8'hF2;
        ram[idx(32'h6000)] = 8'hA1; ram[idx(32'h6001)] = 8'hB2;
        ram[idx(32'h6002)] = 8'hC3; ram[idx(32'h6003)] = 8'hD4;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_welcome", 40'(welcome_lsb), 40'd1);
        chk("rst_ready", 40'(cache_ready), 40'd0);
        chk("rst_type", 40'(cache_instr_type), 40'd0);
        chk("rst_data", 40'(cache_data_out), 40'd0);
        chk("rst_dout", 40'(mem_dout), 40'd0);
        chk("rst_a", 40'(mem_a), 40'd0);
        chk("rst_wr", 40'(mem_wr), 40'd0);
        rst = 1'b0;
        step;
        issue(3'b010, LD, 32'h1000, '0);
        wait_ready(e);
        chk("lw_edges", 40'(e), 40'd5);
        chk("lw_data", 40'(cache_data_out), 40'h44332211);
        chk("lw_type", 40'(cache_instr_type), 40'(LD));
        chk("lw_welcome_pulse", 40'(welcome_lsb), 40'd0);
        step;
        chk("lw_welcome_after", 40'(welcome_lsb), 40'd1);
        for (int i = 0; i < 4; i++) begin
            issue(t_op[i], LD, t_a[i], '0);
            wait_ready(e);
            chk("ld_edges", 40'(e), 40'(t_e[i]));
            chk("ld_data", 40'(cache_data_out), 40'(t_v[i]));
            step;
        end
        wlog.delete();
        issue(3'b010, ST, 32'h3000, 32'hDEADBEEF);
        wait_ready(e);
        chk("sw_edges", 40'(e), 40'd4);
        chk("sw_data", 40'(cache_data_out), 40'd0);
        chk("sw_type", 40'(cache_instr_type), 40'(ST));
        chk("sw_count", 40'(wlog.size()), 40'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("sw_write", wlog[i], {32'h3000 + 32'(i), sw_b[i]});
        step;
        wlog.delete();
        io_buffer_full = 1'b1;
        issue(3'b000, ST, IO, 32'h00000041);
        step;
        step;
        chk("io_hold_wr", 40'(mem_wr), 40'd0);
        step;
        io_buffer_full = 1'b0;
        wait_ready(e);
        chk("io_edges", 40'(e), 40'd4);
        chk("io_count", 40'(wlog.size()), 40'd1);
        if (wlog.size() > 0) chk("io_write", wlog[0], {IO, 8'h41});
        step;
        issue(3'b010, LD, 32'h1000, '0);
        step;
        rob_clear = 1'b1;
        step;
        rob_clear = 1'b0;
        chk("flush_welcome", 40'(welcome_lsb), 40'd1);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (cache_ready) seen++;
            step;
        end
        chk("flush_no_ready", 40'(seen), 40'd0);
        wlog.delete();
        issue(3'b001, ST, 32'h5000, 32'h0000BEEF);
        rob_clear = 1'b1;
        wait_ready(e);
        rob_clear = 1'b0;
        chk("sh_flush_edges", 40'(e), 40'd2);
        chk("sh_flush_count", 40'(wlog.size()), 40'd2);
        if (wlog.size() > 1) chk("sh_flush_hi", wlog[1], {32'h5001, 8'hBE});
        step;
        issue(3'b010, LD, 32'h6000, '0);
        repeat (4) step;
        rdy = 1'b0;
        step;
        chk("frz_a", 40'(mem_a), 40'h6003);
        chk("frz_wr", 40'(mem_wr), 40'd0);
        step;
        rdy = 1'b1;
        wait_ready(e);
        chk("frz_edges", 40'(e), 40'd7);
        chk("frz_data", 40'(cache_data_out), 40'hD4C3B2A1);
        step;
        wlog.delete();
        issue(3'b010, ST, 32'h7000, 32'h12345678);
        step;
        chk("pre_rst_wr", 40'(mem_wr), 40'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_wr", 40'(mem_wr), 40'd0);
        chk("mid_rst_welcome", 40'(welcome_lsb), 40'd1);
        chk("mid_rst_ready", 40'(cache_ready), 40'd0);
        step;
        step;
        rst = 1'b0;
        step;
        chk("rst_wlog", 40'(wlog.size()), 40'd1);
        issue(3'b010, LD, 32'h1000, '0);
        wait_ready(e);
        chk("post_rst_edges", 40'(e), 40'd5);
        chk("post_rst_data", 40'(cache_data_out), 40'h44332211);
        step;
        step;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/lsb_mem_port.md
Name: lsb_mem_port

Overview:
- Memory-side responder for the load/store buffer's cache request interface. It serves exactly one load or store at a time.
- Accesses go to the byte-wide unified RAM bus, byte-serially and little-endian.
- Load data is assembled and sign- or zero-extended, then returned with a one-cycle completion pulse to the load/store buffer, RoB and RS.
- It sits between the load/store buffer and the RAM-bus arbiter.

Parameters:
- IO_BASE, 32'h00030000, start of the memory-mapped IO window (8 bytes) where stores obey io_buffer_full.
- LD_TYPE, 7'b0000011, instr_type code for loads.
- S_TYPE, 7'b0100011, instr_type code for stores.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; low freezes the block
- rob_clear  in  1  pipeline flush
- in_lsb_ready  in  1  request valid
- op_in  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- instr_type_in  in  7  LD_TYPE or S_TYPE
- data_addr_in  in  32  byte address
- data_in  in  32  store data
- welcome_lsb  out  1  idle, request may be issued
- cache_ready  out  1  one-cycle completion pulse
- cache_instr_type  out  7  type of the completed request
- cache_data_out  out  32  extended load result (0 for stores)
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  IO write buffer full

Behaviour:
- Reset (async, rst=1): state=IDLE; welcome_lsb=1, cache_ready=0, cache_instr_type=0, cache_data_out=0, mem_dout=0, mem_a=0, mem_wr=0; byte counter=0; latched request cleared.
- rdy=0: all registers hold and mem_wr is forced to 0 combinationally. rst overrides rdy.
- States:
  - IDLE: welcome_lsb=1.
  - LOAD, STORE: welcome_lsb=0.
  - DONE: welcome_lsb=0, cache_ready=1 for exactly this one cycle.
- Request acceptance:
  - Accept at edge E0 when state=IDLE and in_lsb_ready=1.
  - Latch op, type, address, data. Set N = 1 for op[1:0]=00, 2 for 01, 4 for 10. Clear the byte counter.
  - The issuer must deassert in_lsb_ready or present a new request by the cycle after cache_ready.
- Load timing:
  - RAM read latency is 1: mem_din in cycle k is the byte addressed by mem_a in cycle k-1.
  - mem_wr=0. mem_a = addr+k in cycle k+1 after E0, for k = 0..N-1.
  - Byte k is captured at edge E(k+2) into bits [8k+7:8k].
  - At edge E(N+1): go to DONE, drive the extended result on cache_data_out, set cache_instr_type = LD_TYPE.
  - cache_ready is high in the cycle after E(N+1) (LB: 2 edges, LH: 3, LW: 5).
- Extension:
  - op 000: sign-extend bit 7. op 001: sign-extend bit 15.
  - op 100/101: zero-extend. op 010: unchanged.
- Store timing:
  - For cycles k+1 (k = 0..N-1): mem_wr=1, mem_a=addr+k, mem_dout=data[8k+7:8k].
  - After the last byte: DONE, cache_data_out=0, cache_instr_type=S_TYPE.
  - cache_ready is high N edges after E0.
- IO stall: if the current byte address is in [IO_BASE, IO_BASE+7] and io_buffer_full=1, that store byte is not issued (mem_wr=0) and the counter holds until io_buffer_full=0.
- DONE always returns to IDLE on the next edge. welcome_lsb is high again 1 cycle after the cache_ready cycle.
- Address arithmetic is 32-bit and wraps modulo 2^32; misaligned addresses are legal.
- rob_clear:
  - In LOAD: abort to IDLE next edge. No cache_ready; mem_a holds, mem_wr=0.
  - In STORE: ignored, the store completes (stores are committed).
  - In IDLE: no request is accepted that cycle.
  - In DONE: the pulse still completes.
- Reset mid-operation: immediate return to reset values; no partial pulse, mem_wr=0.

Test Plan:
- LW at 0x1000, RAM bytes 0x11,0x22,0x33,0x44 -> mem_a 0x1000..0x1003 in consecutive cycles; cache_ready for one cycle 5 edges after accept with cache_data_out=0x44332211 and cache_instr_type=LD_TYPE; welcome_lsb low from accept until one cycle after the pulse.
- LB and LBU at a byte holding 0x80 -> 0xFFFFFF80 and 0x00000080. LH and LHU at 0x2001 holding 0x34,0xF2 -> 0xFFFFF234 and 0x0000F234 (misaligned accepted).
- SW 0xDEADBEEF at 0x3000 -> mem_wr=1 for exactly 4 cycles, writing EF,BE,AD,DE to 0x3000..0x3003; cache_ready 4 edges after accept with data 0.
- SB 0x41 to IO_BASE with io_buffer_full=1 for 3 cycles -> mem_wr stays 0 for those 3 cycles, then one write of 0x41; cache_ready follows that write.
- rob_clear in the 2nd LOAD cycle of an LW -> no cache_ready, IDLE next edge, welcome_lsb=1. rob_clear during SH -> both bytes written, cache_ready occurs.
- rdy=0 for 2 cycles mid-LW -> state and outputs frozen, mem_wr=0, completion delayed by exactly 2 cycles. Async rst mid-store -> mem_wr=0 immediately, welcome_lsb=1.
